// File: rtl/ccff_ctrl_pkg.sv
// Shared state encoding and width helper for the configuration-chain programmer.
package ccff_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_NEXT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Width of a counter that must hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Holds one bitstream word and shifts it out LSB first for a programmed number of bits.
module ccff_word_serializer
    import ccff_ctrl_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int NB_W   = cnt_width(WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] word,
    input  logic [NB_W-1:0]   nbits_in,
    output logic              bit_out,
    output logic              last
);

    logic [WORD_W-1:0] shreg;
    logic [NB_W-1:0]   nbits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nbits <= '0;
        end else if (load) begin
            nbits <= nbits_in;
        end else if (shift && (nbits != '0)) begin
            nbits <= nbits - NB_W'(1);
        end
    end

    // Data path only; its contents are meaningless until the next load.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= word;
        end else if (shift) begin
            shreg <= shreg >> 1;
        end
    end

    assign bit_out = shreg[0];
    assign last    = (nbits == NB_W'(1));

endmodule

// File: rtl/ccff_chain_programmer.sv
// Serializes a word-wide bitstream into a configuration chain, gating the chain clock
// so it shifts exactly CHAIN_LEN times, with an optional read-back verify pass.
module ccff_chain_programmer
    import ccff_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 62,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify_en,
    input  logic              abort,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_clk_en,
    output logic              verify_pass,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  err_index
);

    localparam int NB_W = cnt_width(WORD_W);

    logic [2:0]       state;
    logic [CNT_W-1:0] bits_left;
    logic             pass;
    logic             verify_lat;
    logic             load;
    logic             shift_en;
    logic             ser_bit;
    logic             ser_last;
    logic [NB_W-1:0]  nbits_load;

    // abort must drop the handshake and the chain clock in the same cycle it is seen.
    assign busy         = (state != ST_IDLE);
    assign bs_ready     = (state == ST_LOAD) && !abort;
    assign load         = bs_ready && bs_valid;
    assign shift_en     = (state == ST_SHIFT) && !abort;
    assign chain_clk_en = shift_en;
    assign ccff_head    = (state == ST_SHIFT) && ser_bit;
    assign verify_pass  = pass && ((state == ST_LOAD) || (state == ST_SHIFT));
    assign done         = (state == ST_DONE) && !abort;

    // A partial last word only shifts the bits the chain still needs.
    always_comb begin
        nbits_load = NB_W'(WORD_W);
        if (int'(bits_left) < WORD_W) begin
            nbits_load = NB_W'(bits_left);
        end
    end

    ccff_word_serializer #(
        .WORD_W (WORD_W),
        .NB_W   (NB_W)
    ) u_ser (
        .clk      (prog_clk),
        .rst      (pReset),
        .load     (load),
        .shift    (shift_en),
        .word     (bs_data),
        .nbits_in (nbits_load),
        .bit_out  (ser_bit),
        .last     (ser_last)
    );

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state      <= ST_IDLE;
            bits_left  <= '0;
            pass       <= 1'b0;
            verify_lat <= 1'b0;
            error      <= 1'b0;
            err_index  <= '0;
        end else if (abort && (state != ST_IDLE)) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        verify_lat <= verify_en;
                        error      <= 1'b0;
                        err_index  <= '0;
                        bits_left  <= CNT_W'(CHAIN_LEN);
                        pass       <= 1'b0;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (load) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bits_left <= bits_left - CNT_W'(1);
                    // The chain is a pure CHAIN_LEN delay, so the tail replays the first pass.
                    if (pass && (ccff_tail != ccff_head) && !error) begin
                        error     <= 1'b1;
                        err_index <= CNT_W'(CHAIN_LEN) - bits_left;
                    end
                    if (ser_last) begin
                        state <= (bits_left == CNT_W'(1)) ? ST_NEXT : ST_LOAD;
                    end
                end
                ST_NEXT: begin
                    if (verify_lat && !pass) begin
                        pass      <= 1'b1;
                        bits_left <= CNT_W'(CHAIN_LEN);
                        state     <= ST_LOAD;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
